id_pipe_stage: RTL and testbench

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/regfile_np.sv | 53 +++++
 rtl/id_pipe_stage.sv | 119 +++++++++++
 tb/tb_id_pipe_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, immediate formats, default XLEN,
// ECALL encoding and the immediate generator used by the decode stage.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   // Immediate format selected by the major opcode.
   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      imm_type_e t;
      t = IMM_NONE;
      unique case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
         OP_STORE:                 t = IMM_S;
         OP_BRANCH:                t = IMM_B;
         OP_LUI, OP_AUIPC:         t = IMM_U;
         OP_JAL:                   t = IMM_J;
         default:                  t = IMM_NONE;
      endcase
      return t;
   endfunction

   // 32-bit sign-extended immediate; the caller widens it to XLEN.
   function automatic logic [31:0] imm_gen(input logic [31:0] ins);
      logic [31:0] imm;
      imm = '0;
      unique case (imm_type_of(ins[6:0]))
         IMM_I:    imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:    imm = {ins[31:12], 12'b0};
         IMM_J:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:  imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/regfile_np.sv
// Register file with two decode read ports plus NPRED prediction read ports
// and one write port. Index 0 reads zero; indices >= NREGS are ignored.
// Optional macro ID_WB_BYPASS_EN forwards the same-cycle write data to reads.
module regfile_np
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = 32,
   parameter int NPRED = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             we,
   input  logic [4:0]                       waddr,
   input  logic [XLEN-1:0]                  wdata,
   input  logic [(2+NPRED)-1:0][4:0]        raddr,
   output logic [(2+NPRED)-1:0][XLEN-1:0]   rdata
);

   localparam int          NRD    = 2 + NPRED;
   localparam int          IW     = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [5:0]  NREGS6 = 6'(NREGS);

   logic [XLEN-1:0] regs [NREGS];

   logic wr_ok;
   assign wr_ok = we && (waddr != 5'd0) && ({1'b0, waddr} < NREGS6);

   // Storage update: reset clears everything, otherwise a single write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr[IW-1:0]] <= wdata;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [XLEN-1:0] val;
      // Combinational read; zero for x0 and out-of-range indices.
      always_comb begin
         val = '0;
         if (raddr[p] != 5'd0 && {1'b0, raddr[p]} < NREGS6) begin
            val = regs[raddr[p][IW-1:0]];
`ifdef ID_WB_BYPASS_EN
            if (we && waddr == raddr[p]) val = wdata;
`endif
         end
      end
      assign rdata[p] = val;
   end

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: combinational decode, load-use hazard
// stall, flush, and a single registered output bundle with valid/ready.
// Optional macro ID_WB_BYPASS_EN enables writeback-to-read forwarding.
module id_pipe_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = 32,
   parameter int NPRED = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [XLEN-1:0]         pc_i,
   input  logic [31:0]             instr_i,
   input  logic                    flush_i,
   input  logic                    ex_memread_i,
   input  logic [4:0]              ex_rd_i,
   input  logic                    wb_we_i,
   input  logic [4:0]              wb_rd_i,
   input  logic [XLEN-1:0]         wb_data_i,
   input  logic [NPRED*5-1:0]      pred_rs_i,
   output logic [NPRED*XLEN-1:0]   pred_data_o,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         pc_o,
   output logic [XLEN-1:0]         imme_o,
   output logic [XLEN-1:0]         rs1_data_o,
   output logic [XLEN-1:0]         rs2_data_o,
   output logic [4:0]              rs1_o,
   output logic [4:0]              rs2_o,
   output logic [4:0]              rd_o,
   output logic [6:0]              opcode_o,
   output logic [2:0]              func3_o,
   output logic                    func7_o,
   output logic                    ecall_o
);

   localparam int NRD = 2 + NPRED;

   // Decode fields straight from the offered instruction word.
   logic [4:0]      dec_rs1, dec_rs2, dec_rd;
   logic [XLEN-1:0] dec_imm;
   logic            dec_ecall;

   assign dec_rs1   = instr_i[19:15];
   assign dec_rs2   = instr_i[24:20];
   assign dec_rd    = instr_i[11:7];
   assign dec_imm   = XLEN'($signed(imm_gen(instr_i)));
   assign dec_ecall = (instr_i == ECALL_INSTR);

   // Register file: ports 0/1 feed decode, the rest serve branch prediction.
   logic [NRD-1:0][4:0]      rf_raddr;
   logic [NRD-1:0][XLEN-1:0] rf_rdata;

   assign rf_raddr    = {pred_rs_i, dec_rs2, dec_rs1};
   assign pred_data_o = rf_rdata[NRD-1:2];

   regfile_np #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NPRED (NPRED)
   ) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_we_i),
      .waddr (wb_rd_i),
      .wdata (wb_data_i),
      .raddr (rf_raddr),
      .rdata (rf_rdata)
   );

   // Load-use hazard: the EX load produces a register this instruction reads.
   logic hazard, advance, load;

   assign hazard   = in_valid && ex_memread_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == dec_rs1) || (ex_rd_i == dec_rs2));
   assign advance  = !out_valid || out_ready;
   // A flush always consumes the offered instruction so upstream can drop it.
   assign in_ready = flush_i || (advance && !hazard);
   assign load     = in_valid && in_ready && !flush_i;

   // Output bundle register: reset > flush > load > bubble > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         pc_o       <= '0;
         imme_o     <= '0;
         rs1_data_o <= '0;
         rs2_data_o <= '0;
         rs1_o      <= '0;
         rs2_o      <= '0;
         rd_o       <= '0;
         opcode_o   <= '0;
         func3_o    <= '0;
         func7_o    <= 1'b0;
         ecall_o    <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         pc_o       <= pc_i;
         imme_o     <= dec_imm;
         rs1_data_o <= rf_rdata[0];
         rs2_data_o <= rf_rdata[1];
         rs1_o      <= dec_rs1;
         rs2_o      <= dec_rs2;
         rd_o       <= dec_rd;
         opcode_o   <= instr_i[6:0];
         func3_o    <= instr_i[14:12];
         func7_o    <= instr_i[30];
         ecall_o    <= dec_ecall;
      end else if (advance) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Scoreboard bench for id_pipe_stage: a driver issues directed and random
// cycles against an architectural model and queues expected bundles; a
// monitor compares every presented bundle against the queue front.
module tb_id_pipe_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] pc_i = '0, instr_i = '0;
   logic        flush_i = 1'b0, ex_memread_i = 1'b0;
   logic [4:0]  ex_rd_i = '0;
   logic        wb_we_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic [31:0] wb_data_i = '0;
   logic [9:0]  pred_rs_i = '0;
   logic [63:0] pred_data_o;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] pc_o, imme_o, rs1_data_o, rs2_data_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [6:0]  opcode_o;
   logic [2:0]  func3_o;
   logic        func7_o, ecall_o;

   id_pipe_stage #(.XLEN(32), .NREGS(32), .NPRED(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .pred_rs_i(pred_rs_i), .pred_data_o(pred_data_o),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_o(pc_o), .imme_o(imme_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .opcode_o(opcode_o), .func3_o(func3_o), .func7_o(func7_o), .ecall_o(ecall_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc, imme, r1d, r2d;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, ec;
   } bundle_t;

   typedef struct {
      bit          iv;
      logic [31:0] pc, ins;
      bit          fl, exm;
      logic [4:0]  exrd;
      bit          we;
      logic [4:0]  wrd;
      logic [31:0] wd;
      bit          ordy;
      logic [4:0]  p0, p1;
      bit          r;
   } stim_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [32];
   bit          exp_ov = 1'b0;
   bundle_t     sb [$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endfunction

   // Immediate from the ISA field layout, built with signed shifts.
   function automatic logic [31:0] ref_imm(logic [31:0] i);
      int s;
      s = i;
      case (i[6:0])
         7'h03, 7'h13, 7'h67: return s >>> 20;
         7'h23: return ((s >>> 25) << 5) | int'(i[11:7]);
         7'h63: return ((s >>> 31) << 12) | (int'(i[7]) << 11) |
                       (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
         7'h37, 7'h17: return i & 32'hFFFF_F000;
         7'h6f: return ((s >>> 31) << 20) | (int'(i[19:12]) << 12) |
                       (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
         default: return 32'd0;
      endcase
   endfunction

   // Architectural register read as seen during the current cycle.
   function automatic logic [31:0] ref_rd(logic [4:0] idx, stim_t s);
      if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (s.we && s.wrd == idx) return s.wd;
`endif
      return model[idx];
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{iv: 1'b0, pc: 32'd0, ins: 32'h0000_0013, fl: 1'b0, exm: 1'b0, exrd: 5'd0,
            we: 1'b0, wrd: 5'd0, wd: 32'd0, ordy: 1'b1, p0: 5'd0, p1: 5'd0, r: 1'b0};
      return s;
   endfunction

   // One clock of stimulus: drive, check combinational outputs, update model.
   task automatic cyc(input stim_t s);
      bit      haz, rdy;
      bundle_t e;
      @(posedge clk);
      #2;
      rst = s.r; in_valid = s.iv; pc_i = s.pc; instr_i = s.ins; flush_i = s.fl;
      ex_memread_i = s.exm; ex_rd_i = s.exrd; wb_we_i = s.we; wb_rd_i = s.wrd;
      wb_data_i = s.wd; out_ready = s.ordy; pred_rs_i = {s.p1, s.p0};
      #1;
      haz = s.iv && s.exm && s.exrd != 0 &&
            (s.exrd == s.ins[19:15] || s.exrd == s.ins[24:20]);
      rdy = s.fl || ((!exp_ov || s.ordy) && !haz);
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("pred0", 64'(pred_data_o[31:0]), 64'(ref_rd(s.p0, s)));
      chk("pred1", 64'(pred_data_o[63:32]), 64'(ref_rd(s.p1, s)));
      if (s.r) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
         sb.delete();
         exp_ov = 1'b0;
      end else begin
         if (s.fl) exp_ov = 1'b0;
         else if (s.iv && rdy) begin
            e.pc = s.pc; e.imme = ref_imm(s.ins);
            e.r1d = ref_rd(s.ins[19:15], s); e.r2d = ref_rd(s.ins[24:20], s);
            e.rs1 = s.ins[19:15]; e.rs2 = s.ins[24:20]; e.rd = s.ins[11:7];
            e.op = s.ins[6:0]; e.f3 = s.ins[14:12]; e.f7 = s.ins[30];
            e.ec = (s.ins == 32'h73);
            sb.push_back(e);
            exp_ov = 1'b1;
         end else if (!exp_ov || s.ordy) exp_ov = 1'b0;
         if (s.we && s.wrd != 0) model[s.wrd] = s.wd;
      end
   endtask

   task automatic check_zero(string nm);
      chk(nm, 64'(|{out_valid, pc_o, imme_o, rs1_data_o, rs2_data_o, rs1_o, rs2_o,
                    rd_o, opcode_o, func3_o, func7_o, ecall_o}), 64'd0);
   endtask

   // Monitor: compare the presented bundle every cycle; retire it when taken
   // downstream or flushed.
   always @(negedge clk) begin
      bundle_t a;
      if (!rst && out_valid === 1'b1) begin
         a = '{pc: pc_o, imme: imme_o, r1d: rs1_data_o, r2d: rs2_data_o, rs1: rs1_o,
               rs2: rs2_o, rd: rd_o, op: opcode_o, f3: func3_o, f7: func7_o, ec: ecall_o};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL bundle unexpected got %h expected none", a);
         end else begin
            if (a !== sb[0]) begin
               errors++;
               $display("FAIL bundle got %h expected %h", a, sb[0]);
            end
            if (out_ready || flush_i) void'(sb.pop_front());
         end
      end
   end

   initial begin
      stim_t  s;
      logic [6:0] ops [11];
      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h73, 7'h0f};
      for (int i = 0; i < 32; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_zero("reset_state");
      chk("reset_pred", pred_data_o, 64'd0);

      // Write x5, then addi x5,x5,5.
      s = idle(); s.we = 1; s.wrd = 5; s.wd = 32'h1234; cyc(s);
      s = idle(); s.iv = 1; s.pc = 32'h100; s.ins = 32'h0052_8293; s.p0 = 5; cyc(s);
      // Load-use hazard on x6, then released.
      s = idle(); s.iv = 1; s.pc = 32'h104; s.ins = 32'h0013_03B3; s.exm = 1; s.exrd = 6; cyc(s);
      s.exm = 0; cyc(s);
      // Downstream stall for 3 cycles with a new instruction offered.
      s = idle(); s.iv = 1; s.pc = 32'h108; s.ins = 32'h0052_8293; s.ordy = 0;
      repeat (3) cyc(s);
      s.ordy = 1; cyc(s);
      // Flush while holding a bundle and offering another.
      s = idle(); s.iv = 1; s.pc = 32'h10C; s.ins = 32'hFFF0_0113; s.ordy = 0; cyc(s);
      s.fl = 1; cyc(s);
      s = idle(); cyc(s);
      // Same-cycle write of x3 and read of x3; then writes to x0.
      s = idle(); s.we = 1; s.wrd = 3; s.wd = 32'h11; cyc(s);
      s = idle(); s.iv = 1; s.pc = 32'h110; s.ins = 32'h0001_8093;
      s.we = 1; s.wrd = 3; s.wd = 32'hAA; s.p0 = 3; s.p1 = 3; cyc(s);
      s = idle(); s.iv = 1; s.pc = 32'h114; s.ins = 32'h0010_0113;
      s.we = 1; s.wrd = 0; s.wd = 32'hFF; s.p0 = 0; cyc(s);
      s = idle(); s.p1 = 3; cyc(s);
      // Reset mid-stream with a held bundle, competing write and load.
      s = idle(); s.iv = 1; s.pc = 32'h118; s.ins = 32'h0052_8293; s.ordy = 0; cyc(s);
      s.r = 1; s.we = 1; s.wrd = 5; s.wd = 32'h55; s.fl = 1; cyc(s);
      s = idle(); s.p0 = 5; s.p1 = 5; cyc(s);
      check_zero("reset_mid");

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         s = idle();
         s.iv   = ($urandom_range(0, 3) != 0);
         s.pc   = $urandom;
         s.ins  = $urandom;
         s.ins[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 15) == 0) s.ins = 32'h73;
         s.fl   = ($urandom_range(0, 19) == 0);
         s.exm  = ($urandom_range(0, 3) == 0);
         s.exrd = $urandom_range(0, 1) ? s.ins[19:15] : 5'($urandom);
         s.we   = ($urandom_range(0, 1) == 0);
         s.wrd  = 5'($urandom_range(0, 7));
         s.wd   = $urandom;
         s.ordy = ($urandom_range(0, 3) != 0);
         s.p0   = 5'($urandom_range(0, 7));
         s.p1   = 5'($urandom);
         s.ins[19:15] = 5'($urandom_range(0, 7));
         s.r    = (n == 300);
         cyc(s);
      end
      s = idle(); repeat (3) cyc(s);
      chk("drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
